// File: rtl/qtu_pkg.sv
// Shared constants and state encoding for the Q-table-update packet filter.
// Packet word order, packet types and the filter FSM states live here.
package qtu_pkg;

    localparam int DEF_WORD_WIDTH   = 16;
    localparam int DEF_PKT_WORDS    = 8;
    localparam int DEF_DONE_TIMEOUT = 64;

    localparam int PKT_HB   = 1;
    localparam int PKT_CH   = 2;
    localparam int PKT_MR   = 3;
    localparam int PKT_DATA = 4;

    localparam int IDX_TYPE       = 0;
    localparam int IDX_SOURCEID   = 1;
    localparam int IDX_DESTID     = 2;
    localparam int IDX_SOURCEHOPS = 3;
    localparam int IDX_QVALUE     = 4;
    localparam int IDX_ENERGY     = 5;
    localparam int IDX_HOPSFROMCH = 6;
    localparam int IDX_CHOSENCH   = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_EVAL,
        S_FIRE,
        S_WAIT
    } state_t;

endpackage

// File: rtl/pkt_word_capture.sv
// Word counter plus indexed packet register file. A start-of-packet word always
// lands in slot 0 and restarts the count, which is how an aborted packet is replaced.
module pkt_word_capture #(
    parameter int WORD_WIDTH = 16,
    parameter int PKT_WORDS  = 8
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic                                 accept,
    input  logic                                 in_recv,
    input  logic                                 sop,
    input  logic [WORD_WIDTH-1:0]                word,
    output logic [PKT_WORDS-1:0][WORD_WIDTH-1:0] words,
    output logic                                 last,
    output logic                                 abort
);

    localparam int CW = $clog2(PKT_WORDS);

    logic [CW-1:0] cnt;

    assign abort = accept && in_recv && sop;
    assign last  = accept && in_recv && !sop && (cnt == CW'(PKT_WORDS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (accept && sop) begin
            cnt <= CW'(1);
        end else if (accept && in_recv) begin
            cnt <= cnt + 1'b1;
        end
    end

    // NOTE: the word store has no reset; it is only ever read after a full
    // packet has overwritten every slot, so reset would add fan-out for nothing.
    always_ff @(posedge clk) begin
        if (accept && sop) begin
            words[0] <= word;
        end else if (accept && in_recv) begin
            words[cnt] <= word;
        end
    end

endmodule

// File: rtl/qtu_packet_filter.sv
// Packet filter in front of the Q-table update: captures a fixed-length packet,
// filters on cluster membership, fires the downstream stage and waits for QTU_done.
module qtu_packet_filter
    import qtu_pkg::*;
#(
    parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
    parameter int PKT_WORDS    = DEF_PKT_WORDS,
    parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic [WORD_WIDTH-1:0] in_word,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] myChosenCH,
    input  logic                  QTU_done,
    output logic                  en,
    output logic                  iAmDestination,
    output logic [WORD_WIDTH-1:0] fSourceID,
    output logic [WORD_WIDTH-1:0] fSourceHops,
    output logic [WORD_WIDTH-1:0] fQValue,
    output logic [WORD_WIDTH-1:0] fEnergyLeft,
    output logic [WORD_WIDTH-1:0] fHopsFromCH,
    output logic [WORD_WIDTH-1:0] fChosenCH,
    output logic [WORD_WIDTH-1:0] fPktType,
    output logic [WORD_WIDTH-1:0] dropCount,
    output logic                  timeoutErr
);

    localparam int TW = $clog2(DONE_TIMEOUT + 1);

    state_t                               state, state_nx;
    logic [PKT_WORDS-1:0][WORD_WIDTH-1:0] words;
    logic                                 accept, cap_last, cap_abort;
    logic                                 type_ok, pass, is_dest, drop_evt, timeout;
    logic [TW-1:0]                        wait_cnt;

    // Ready depends on state alone, so acceptance never loops back through the FSM.
    assign in_ready = (state == S_IDLE) || (state == S_RECV);
    assign accept   = in_valid && in_ready;

    pkt_word_capture #(
        .WORD_WIDTH (WORD_WIDTH),
        .PKT_WORDS  (PKT_WORDS)
    ) u_capture (
        .clk     (clk),
        .nrst    (nrst),
        .accept  (accept),
        .in_recv (state == S_RECV),
        .sop     (in_sop),
        .word    (in_word),
        .words   (words),
        .last    (cap_last),
        .abort   (cap_abort)
    );

    assign type_ok = (words[IDX_TYPE] == WORD_WIDTH'(PKT_MR))
                  || (words[IDX_TYPE] == WORD_WIDTH'(PKT_DATA));
    assign pass    = type_ok
                  && (words[IDX_SOURCEID] != myNodeID)
                  && (words[IDX_CHOSENCH] == myChosenCH);
    assign is_dest = (words[IDX_TYPE] == WORD_WIDTH'(PKT_DATA))
                  && (words[IDX_DESTID] == myNodeID);

    assign drop_evt = cap_abort || ((state == S_EVAL) && !pass);
    // A done pulse on the final wait cycle wins over the timeout.
    assign timeout  = (state == S_WAIT) && !QTU_done
                   && (wait_cnt == TW'(DONE_TIMEOUT - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nx = state;
        en       = 1'b0;
        case (state)
            S_IDLE: if (accept && in_sop) state_nx = S_RECV;
            S_RECV: if (cap_last)         state_nx = S_EVAL;
            S_EVAL: state_nx = pass ? S_FIRE : S_IDLE;
            S_FIRE: begin
                en       = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: if (QTU_done || timeout) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fSourceID      <= '0;
            fSourceHops    <= '0;
            fQValue        <= '0;
            fEnergyLeft    <= '0;
            fHopsFromCH    <= '0;
            fChosenCH      <= '0;
            fPktType       <= '0;
            iAmDestination <= 1'b0;
        end else if (state == S_EVAL) begin
            fSourceID      <= words[IDX_SOURCEID];
            fSourceHops    <= words[IDX_SOURCEHOPS];
            fQValue        <= words[IDX_QVALUE];
            fEnergyLeft    <= words[IDX_ENERGY];
            fHopsFromCH    <= words[IDX_HOPSFROMCH];
            fChosenCH      <= words[IDX_CHOSENCH];
            fPktType       <= words[IDX_TYPE];
            iAmDestination <= is_dest;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dropCount  <= '0;
            timeoutErr <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            if (drop_evt && (dropCount != '1)) dropCount <= dropCount + 1'b1;
            if (timeout) timeoutErr <= 1'b1;
            if (state == S_FIRE) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule
